// File: rtl/apb_slv_adapter.sv
// APB completer front-end: turns one APB transfer into a valid/ready request to a
// peripheral core, waits for its response and bounds the wait with a timeout.
module apb_slv_adapter #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_psel,
    input  logic                 i_penable,
    input  logic                 i_pwrite,
    input  logic [31:0]          i_paddr,
    input  logic [31:0]          i_pwdata,
    input  logic [3:0]           i_pstrb,
    input  logic [2:0]           i_pprot,
    output logic                 o_pready,
    output logic [31:0]          o_prdata,
    output logic                 o_pslverr,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic [ADDR_BITS-1:0] o_req_addr,
    output logic                 o_req_write,
    output logic [31:0]          o_req_wdata,
    output logic [3:0]           o_req_wstrb,
    output logic [2:0]           o_req_prot,
    input  logic                 i_resp_valid,
    input  logic [31:0]          i_resp_rdata,
    input  logic                 i_resp_err
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);
    localparam logic             TMO_EN_C = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   tmo_s;
    logic                   unused_paddr_s;

    logic                   pready_q;
    logic [31:0]            prdata_q;
    logic                   pslverr_q;
    logic                   req_valid_q;
    logic [ADDR_BITS-1:0]   req_addr_q;
    logic                   req_write_q;
    logic [31:0]            req_wdata_q;
    logic [3:0]             req_wstrb_q;
    logic [2:0]             req_prot_q;

    // Only the peripheral-local offset is forwarded; upper address bits decode the select.
    assign unused_paddr_s = ^i_paddr[31:ADDR_BITS];

    assign cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + CNT_W'(1);
    assign tmo_s = TMO_EN_C && (cnt_q == TMO_C);

    // Transfer sequencer: capture, request, response/timeout, one-cycle completion.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= 32'h0;
            pslverr_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'h0;
            req_prot_q  <= 3'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_psel && !i_penable) begin
                        req_addr_q  <= i_paddr[ADDR_BITS-1:0];
                        req_write_q <= i_pwrite;
                        req_wdata_q <= i_pwdata;
                        req_wstrb_q <= i_pwrite ? i_pstrb : 4'h0;
                        req_prot_q  <= i_pprot;
                        cnt_q       <= '0;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_d;
                    if (i_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else if (tmo_s) begin
                        req_valid_q <= 1'b0;
                        pready_q    <= 1'b1;
                        pslverr_q   <= 1'b1;
                        prdata_q    <= 32'h0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // A real response in the same cycle as expiry takes precedence.
                    if (i_resp_valid) begin
                        prdata_q  <= req_write_q ? 32'h0 : i_resp_rdata;
                        pslverr_q <= i_resp_err;
                        pready_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (tmo_s) begin
                        prdata_q  <= 32'h0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= 32'h0;
                    pslverr_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    pready_q    <= 1'b0;
                    prdata_q    <= 32'h0;
                    pslverr_q   <= 1'b0;
                    req_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pready    = pready_q;
    assign o_prdata    = prdata_q;
    assign o_pslverr   = pslverr_q;
    assign o_req_valid = req_valid_q;
    assign o_req_addr  = req_addr_q;
    assign o_req_write = req_write_q;
    assign o_req_wdata = req_wdata_q;
    assign o_req_wstrb = req_wstrb_q;
    assign o_req_prot  = req_prot_q;

endmodule

// File: tb/tb_apb_slv_adapter.sv
// Bench for apb_slv_adapter: two instances (TIMEOUT=8 and TIMEOUT=4) share one
// stimulus stream and are compared cycle by cycle against a latency/outcome model.
module tb_apb_slv_adapter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [3:0]  pstrb = 4'h0;
    logic [2:0]  pprot = 3'h0;
    logic        req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;
    logic [31:0] resp_rdata = 32'h0;

    logic [1:0]        pready, pslverr, req_valid, req_write;
    logic [1:0][31:0]  prdata, req_wdata;
    logic [1:0][11:0]  req_addr;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0][2:0]   req_prot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_slv_adapter #(.ADDR_BITS(12), .TIMEOUT(8)) u_dut8 (
        .i_clk(clk), .i_nrst(nrst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb), .i_pprot(pprot),
        .o_pready(pready[0]), .o_prdata(prdata[0]), .o_pslverr(pslverr[0]),
        .o_req_valid(req_valid[0]), .i_req_ready(req_ready), .o_req_addr(req_addr[0]),
        .o_req_write(req_write[0]), .o_req_wdata(req_wdata[0]), .o_req_wstrb(req_wstrb[0]),
        .o_req_prot(req_prot[0]), .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata),
        .i_resp_err(resp_err)
    );

    apb_slv_adapter #(.ADDR_BITS(12), .TIMEOUT(4)) u_dut4 (
        .i_clk(clk), .i_nrst(nrst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb), .i_pprot(pprot),
        .o_pready(pready[1]), .o_prdata(prdata[1]), .o_pslverr(pslverr[1]),
        .o_req_valid(req_valid[1]), .i_req_ready(req_ready), .o_req_addr(req_addr[1]),
        .o_req_write(req_write[1]), .o_req_wdata(req_wdata[1]), .o_req_wstrb(req_wstrb[1]),
        .o_req_prot(req_prot[1]), .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata),
        .i_resp_err(resp_err)
    );

    function automatic int to_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s pready d%0d", tag, d),    32'(pready[d]),    32'h0);
            chk($sformatf("%s prdata d%0d", tag, d),    prdata[d],         32'h0);
            chk($sformatf("%s pslverr d%0d", tag, d),   32'(pslverr[d]),   32'h0);
            chk($sformatf("%s req_valid d%0d", tag, d), 32'(req_valid[d]), 32'h0);
            chk($sformatf("%s req_addr d%0d", tag, d),  32'(req_addr[d]),  32'h0);
            chk($sformatf("%s req_write d%0d", tag, d), 32'(req_write[d]), 32'h0);
            chk($sformatf("%s req_wdata d%0d", tag, d), req_wdata[d],      32'h0);
            chk($sformatf("%s req_wstrb d%0d", tag, d), 32'(req_wstrb[d]), 32'h0);
            chk($sformatf("%s req_prot d%0d", tag, d),  32'(req_prot[d]),  32'h0);
        end
    endtask

    // Outcome model: ready after r stall cycles, response s cycles after the handshake.
    // Returns the cycle (setup = 0) on which pready is high, plus the completion values.
    task automatic model(input int to, input int r, input int s, input logic wr,
                         input logic [31:0] rdata, input logic rerr,
                         output int pc, output logic err, output logic [31:0] data);
        if (r > to) begin
            pc = to + 2; err = 1'b1; data = 32'h0;
        end else if (s > 0 && r + s >= to) begin
            pc = (r == to) ? to + 3 : to + 2; err = 1'b1; data = 32'h0;
        end else begin
            pc = 3 + r + s; err = rerr; data = wr ? 32'h0 : rdata;
        end
    endtask

    // Entered just after a rising edge; leaves just after a rising edge with the bus idle.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                           input int r, input int s, input logic [31:0] rdata, input logic rerr);
        int          pc [2];
        logic        ex_err [2];
        logic [31:0] ex_data [2];
        int          last;
        int          rv_end;
        for (int d = 0; d < 2; d++)
            model(to_of(d), r, s, wr, rdata, rerr, pc[d], ex_err[d], ex_data[d]);
        last = (pc[0] > pc[1]) ? pc[0] : pc[1];
        if (2 + r + s > last) last = 2 + r + s;
        last = last + 1;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                psel = 1'b1; penable = 1'b0; pwrite = wr;
                paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
            end else begin
                penable = 1'b1;
                paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
            end
            req_ready  = (k == 1 + r);
            resp_valid = (k == 2 + r + s);
            resp_rdata = (k == 2 + r + s) ? rdata : $urandom;
            resp_err   = (k == 2 + r + s) ? rerr : 1'($urandom);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rv_end = ((r < to_of(d)) ? r : to_of(d)) + 1;
                chk($sformatf("%s pready d%0d k%0d", name, d, k), 32'(pready[d]), 32'(k == pc[d]));
                chk($sformatf("%s req_valid d%0d k%0d", name, d, k), 32'(req_valid[d]),
                    32'(k >= 1 && k <= rv_end));
                chk($sformatf("%s prdata d%0d k%0d", name, d, k), prdata[d],
                    (k == pc[d]) ? ex_data[d] : 32'h0);
                chk($sformatf("%s pslverr d%0d k%0d", name, d, k), 32'(pslverr[d]),
                    (k == pc[d]) ? 32'(ex_err[d]) : 32'h0);
                if (k >= 1) begin
                    chk($sformatf("%s req_addr d%0d k%0d", name, d, k), 32'(req_addr[d]), 32'(addr[11:0]));
                    chk($sformatf("%s req_write d%0d k%0d", name, d, k), 32'(req_write[d]), 32'(wr));
                    chk($sformatf("%s req_wdata d%0d k%0d", name, d, k), req_wdata[d], wdata);
                    chk($sformatf("%s req_wstrb d%0d k%0d", name, d, k), 32'(req_wstrb[d]),
                        wr ? 32'(strb) : 32'h0);
                    chk($sformatf("%s req_prot d%0d k%0d", name, d, k), 32'(req_prot[d]), 32'(prot));
                end
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        run_txn("rd_fast", 1'b0, 32'h0000_0104, 32'h0, 4'hF, 3'h2, 0, 0, 32'hDEAD_BEEF, 1'b0);
        run_txn("wr_stall", 1'b1, 32'h4000_0A20, 32'h1234_5678, 4'h3, 3'h1, 4, 2, 32'hFFFF_FFFF, 1'b0);
        run_txn("rd_err", 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 3'h7, 1, 1, 32'hCAFE_F00D, 1'b1);
        run_txn("timeout", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'h0, 20, 0, 32'h5555_AAAA, 1'b0);
        run_txn("collide4", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'h3, 4, 0, 32'h0BAD_F00D, 1'b0);
        run_txn("collide8", 1'b1, 32'h0000_0300, 32'hA5A5_5A5A, 4'hC, 3'h4, 8, 0, 32'h1111_2222, 1'b1);
        run_txn("wait_to", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'h5, 2, 9, 32'h7777_8888, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rnd%0d", i), 1'($urandom), $urandom, $urandom, 4'($urandom),
                    3'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                    $urandom, 1'($urandom));
        end

        // Reset asserted mid-WaitResp, away from any clock edge.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0000_0ABC; pwdata = 32'h9999_0000; pstrb = 4'hF; pprot = 3'h6;
        @(posedge clk); #1;
        penable = 1'b1; req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        @(posedge clk); #1;
        #1 nrst = 1'b0;
        #1 chk_all_zero("async_rst");
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst_hold");
        nrst = 1'b1;
        @(posedge clk); #1;
        run_txn("post_rst", 1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'h0, 0, 0, 32'h0123_4567, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
